ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_ctrl
// Brief    : Burst read/write controller for a synchronous single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_write = 3'd1;
    localparam logic [2:0] c_read  = 3'd2;
    localparam logic [2:0] c_drain = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rd_valid;
    logic [ADDR_W:0]   w_len_eff;
    logic [ADDR_W:0]   w_cnt_inc;
    logic [ADDR_W-1:0] w_addr;
    logic              w_xfer;

    // Oversized requests saturate to the full RAM depth.
    assign w_len_eff = (len > c_depth) ? c_depth : len;
    assign w_cnt_inc = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_addr    = r_base + r_cnt[ADDR_W-1:0];
    assign w_xfer    = wr_valid && (r_state == c_write);

    assign rd_data   = ram_q;
    assign rd_valid  = r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_base     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            // RAM returns data one cycle after the address is issued.
            r_rd_valid <= (r_state == c_read);
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= w_len_eff;
                        r_cnt  <= '0;
                    end
                end
                c_write: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_read: begin
                    r_cnt <= w_cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        wr_ready     = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_data     = '0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    if (len == '0) begin
                        w_next_state = c_done;
                    end else if (wr_mode) begin
                        w_next_state = c_write;
                    end else begin
                        w_next_state = c_read;
                    end
                end
            end
            c_write: begin
                busy     = 1'b1;
                wr_ready = 1'b1;
                ram_we   = w_xfer;
                ram_addr = w_addr;
                ram_data = wr_data;
                if (w_xfer && (w_cnt_inc == r_len)) begin
                    w_next_state = c_done;
                end
            end
            c_read: begin
                busy     = 1'b1;
                ram_addr = w_addr;
                if (w_cnt_inc == r_len) begin
                    w_next_state = c_drain;
                end
            end
            c_drain: begin
                busy         = 1'b1;
                w_next_state = c_done;
            end
            c_done: begin
                done         = 1'b1;
                w_next_state = c_idle;
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_ctrl
// Brief    : Self-checking bench for ram_access_ctrl with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_access_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       wr_mode;
    logic [5:0] base_addr;
    logic [6:0] len;
    logic       busy;
    logic       done;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    typedef struct {
        bit         wr;
        logic [5:0] base;
        logic [6:0] len;
        logic [7:0] seed;
        bit         gap;
        bit         poke;
        int         exp_words;
        int         exp_busy;
        string      name;
    } vec_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } wexp_t;

    vec_t       vecs[9];
    vec_t       v_post;
    wexp_t      wq[$];
    logic [7:0] rq[$];
    logic [7:0] shadow[64];
    logic [7:0] mem[64];
    wexp_t      e;
    logic [7:0] r_e;
    logic [5:0] gapmask;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int rv_cnt   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -10;
    int last_we  = -10;
    int last_rv  = -10;
    int first_rv = -10;

    ram_access_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_mode   (wr_mode),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: read data appears the cycle after the address edge.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output monitor and scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) chk("idle_quiet", {16'd0, ram_we, wr_ready, ram_addr, ram_data}, 32'd0);
            if (ram_we) begin
                we_cnt++;
                last_we = cyc;
                if (wq.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
                else begin
                    e = wq.pop_front();
                    chk("we_addr", {26'd0, ram_addr}, {26'd0, e.addr});
                    chk("we_data", {24'd0, ram_data}, {24'd0, e.data});
                end
            end
            if (rd_valid) begin
                rv_cnt++;
                if (last_rv != cyc - 1) first_rv = cyc;
                last_rv = cyc;
                if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    r_e = rq.pop_front();
                    chk("rd_data", {24'd0, rd_data}, {24'd0, r_e});
                end
            end
        end
    end

    task automatic run_burst(input vec_t c);
        int         s;
        int         we0;
        int         rv0;
        int         bz0;
        int         dn0;
        int         w;
        int         exp_done;
        bit         v;
        logic [5:0] a;
        we0 = we_cnt;
        rv0 = rv_cnt;
        bz0 = busy_cnt;
        dn0 = done_cnt;
        for (int i = 0; i < c.exp_words; i++) begin
            a = 6'(c.base + 6'(i));
            if (c.wr) begin
                wq.push_back('{a, 8'(c.seed + 8'(i))});
                shadow[a] = 8'(c.seed + 8'(i));
            end else begin
                rq.push_back(shadow[a]);
            end
        end
        @(posedge clk); #1;
        start     = 1'b1;
        wr_mode   = c.wr;
        base_addr = c.base;
        len       = c.len;
        s         = cyc;
        v         = 1'b0;
        w         = 0;
        for (int j = 0; j < 300; j++) begin
            @(posedge clk); #1;
            if (v) w++;
            start = c.poke && (j == 1);
            if (start) begin
                wr_mode   = 1'b0;
                base_addr = 6'd40;
                len       = 7'd3;
            end
            if (!c.wr || w >= c.exp_words) break;
            v        = c.gap ? gapmask[j % 6] : 1'b1;
            wr_valid = v;
            wr_data  = 8'(c.seed + 8'(w));
            #3 chk({c.name, " wr_ready"}, {31'd0, wr_ready}, 32'd1);
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        for (int j = 0; j < 300; j++) begin
            if (done_cnt != dn0) break;
            @(posedge clk);
        end
        @(posedge clk); #1;
        if (c.exp_words == 0) exp_done = s + 1;
        else exp_done = c.wr ? last_we + 1 : last_rv + 1;
        chk({c.name, " done_count"}, done_cnt - dn0, 32'd1);
        chk({c.name, " done_cycle"}, done_cyc, exp_done);
        chk({c.name, " we_count"}, we_cnt - we0, c.wr ? c.exp_words : 0);
        chk({c.name, " rv_count"}, rv_cnt - rv0, c.wr ? 0 : c.exp_words);
        chk({c.name, " busy_cycles"}, busy_cnt - bz0, c.exp_busy);
        if (!c.wr && c.exp_words > 0)
            chk({c.name, " rv_contiguous"}, last_rv - first_rv + 1, c.exp_words);
        chk({c.name, " sb_empty"}, wq.size() + rq.size(), 32'd0);
        wq.delete();
        rq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int dn0;
        gapmask = 6'b101001;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        //          wr    base   len    seed   gap   poke  words busy  name
        vecs[0] = '{1'b1, 6'd0,  7'd5,   8'h00, 1'b0, 1'b0, 5,  5,  "wr5"};
        vecs[1] = '{1'b0, 6'd0,  7'd5,   8'h00, 1'b0, 1'b0, 5,  6,  "rd5"};
        vecs[2] = '{1'b1, 6'd20, 7'd3,   8'h30, 1'b1, 1'b0, 3,  6,  "wrgap"};
        vecs[3] = '{1'b1, 6'd62, 7'd4,   8'h50, 1'b0, 1'b0, 4,  4,  "wrwrap"};
        vecs[4] = '{1'b0, 6'd62, 7'd4,   8'h00, 1'b0, 1'b0, 4,  5,  "rdwrap"};
        vecs[5] = '{1'b1, 6'd10, 7'd0,   8'h00, 1'b0, 1'b0, 0,  0,  "wr0"};
        vecs[6] = '{1'b0, 6'd10, 7'd0,   8'h00, 1'b0, 1'b0, 0,  0,  "rd0"};
        vecs[7] = '{1'b1, 6'd30, 7'd4,   8'h90, 1'b0, 1'b1, 4,  4,  "poke"};
        vecs[8] = '{1'b0, 6'd0,  7'd100, 8'h00, 1'b0, 1'b0, 64, 65, "rd100"};
        v_post  = '{1'b0, 6'd0,  7'd2,   8'h00, 1'b0, 1'b0, 2,  3,  "rd_after_abort"};

        rst = 1'b0; start = 1'b0; wr_mode = 1'b0; base_addr = '0; len = '0;
        wr_data = '0; wr_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("reset ram_we", {31'd0, ram_we}, 32'd0);
        chk("reset ram_addr", {26'd0, ram_addr}, 32'd0);
        chk("reset ram_data", {24'd0, ram_data}, 32'd0);
        chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) run_burst(vecs[i]);

        // Abort a 5-word write with reset while the 3rd word is on the bus.
        we0 = we_cnt;
        dn0 = done_cnt;
        wq.push_back('{6'd0, 8'hA0});
        wq.push_back('{6'd1, 8'hA1});
        shadow[0] = 8'hA0;
        shadow[1] = 8'hA1;
        @(posedge clk); #1;
        start = 1'b1; wr_mode = 1'b1; base_addr = 6'd0; len = 7'd5;
        @(posedge clk); #1;
        start = 1'b0; wr_valid = 1'b1; wr_data = 8'hA0;
        @(posedge clk); #1 wr_data = 8'hA1;
        @(posedge clk); #1 wr_data = 8'hA2;
        #1 rst = 1'b1;
        #1;
        chk("abort ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("abort ram_addr", {26'd0, ram_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort we_count", we_cnt - we0, 32'd2);
        chk("abort no_done", done_cnt - dn0, 32'd0);
        chk("abort sb_empty", wq.size(), 32'd0);
        wq.delete();

        run_burst(v_post);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
